// File: rtl/video_scale_pkg.sv
// Shared pixel and FIFO-entry types for the video scaler pipeline
// (downscaler -> stream packer).
package video_scale_pkg;

  localparam int PIXEL_DEPTH = 8;
  localparam int PIXEL_COLOR = 3;

  typedef logic [PIXEL_COLOR-1:0][PIXEL_DEPTH-1:0] pixel_t;

  typedef struct packed {
    pixel_t pixel;
    logic   sof;
    logic   eol;
  } fifo_entry_t;

  // Entries are packed as {pixel, sof, eol}; the flags occupy the low bits.
  localparam int ENTRY_FLAG_W  = 2;
  localparam int ENTRY_SOF_BIT = 1;
  localparam int ENTRY_EOL_BIT = 0;

  // A zero resolution would make the counter wrap points undefined.
  function automatic logic [15:0] clamp_res(input logic [15:0] res);
    return (res == 16'd0) ? 16'd1 : res;
  endfunction

endpackage

// File: rtl/video_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy level and synchronous flush.
// The head entry is visible on rd_data whenever the FIFO is not empty.
module video_sync_fifo #(
  parameter int DATA_W = 26,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   LVL_FULL = {1'b1, {AW{1'b0}}};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              push;
  logic              pop;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign level = level_q;
  assign push  = wr_en & ~full & ~flush;
  assign pop   = rd_en & ~empty & ~flush;

  // Drive zeros while empty so the output bus never shows stale entries.
  assign rd_data = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/video_scale_stream_packer.sv
// Frames the downscaler's pixel stream: tags each pixel with sof/eol from
// write-side x/y counters and buffers it in a show-ahead FIFO.
module video_scale_stream_packer #(
  parameter int iPIXEL_DEPTH = 8,
  parameter int iPIXEL_COLOR = 3,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                                 vin_clk,
  input  logic                                 rst,
  input  logic                                 frame_sync_n,
  input  logic [iPIXEL_COLOR*iPIXEL_DEPTH-1:0] vin_dat,
  input  logic                                 vin_valid,
  output logic                                 vin_ready,
  output logic [iPIXEL_COLOR*iPIXEL_DEPTH-1:0] vout_dat,
  output logic                                 vout_valid,
  input  logic                                 vout_ready,
  output logic                                 vout_sof,
  output logic                                 vout_eol,
  input  logic [15:0]                          vout_xres,
  input  logic [15:0]                          vout_yres,
  output logic                                 frame_done,
  output logic [$clog2(FIFO_DEPTH):0]          fifo_level
);

  import video_scale_pkg::*;

  localparam int PIX_W   = iPIXEL_COLOR * iPIXEL_DEPTH;
  localparam int ENTRY_W = PIX_W + ENTRY_FLAG_W;

  logic [15:0]        xres_l_q, xres_l_d;
  logic [15:0]        yres_l_q, yres_l_d;
  logic [15:0]        wr_x_q, wr_x_d;
  logic [15:0]        wr_y_q, wr_y_d;
  logic               frame_done_q, frame_done_d;

  logic               fifo_full;
  logic               fifo_empty;
  logic               wr_fire;
  logic               at_eol;
  logic               at_last_line;
  logic               at_sof;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  // Ready is never gated by vout_ready: a full FIFO blocks input even if a
  // read frees a slot in the same cycle.
  assign vin_ready    = ~rst & frame_sync_n & ~fifo_full;
  assign wr_fire      = vin_valid & vin_ready;

  assign at_sof       = (wr_x_q == 16'd0) && (wr_y_q == 16'd0);
  assign at_eol       = (wr_x_q == xres_l_q - 16'd1);
  assign at_last_line = (wr_y_q == yres_l_q - 16'd1);

  always_comb begin
    wr_entry                              = '0;
    wr_entry[ENTRY_W-1:ENTRY_FLAG_W]      = vin_dat;
    wr_entry[ENTRY_SOF_BIT]               = at_sof;
    wr_entry[ENTRY_EOL_BIT]               = at_eol;
  end

  always_comb begin
    xres_l_d     = xres_l_q;
    yres_l_d     = yres_l_q;
    wr_x_d       = wr_x_q;
    wr_y_d       = wr_y_q;
    frame_done_d = 1'b0;
    if (!frame_sync_n) begin
      xres_l_d = clamp_res(vout_xres);
      yres_l_d = clamp_res(vout_yres);
      wr_x_d   = 16'd0;
      wr_y_d   = 16'd0;
    end else if (wr_fire) begin
      frame_done_d = at_eol & at_last_line;
      if (at_eol) begin
        // Lines past the programmed height wrap back to a new frame.
        wr_x_d = 16'd0;
        wr_y_d = at_last_line ? 16'd0 : wr_y_q + 16'd1;
      end else begin
        wr_x_d = wr_x_q + 16'd1;
      end
    end
  end

  always_ff @(posedge vin_clk) begin
    if (rst) begin
      xres_l_q     <= 16'd1;
      yres_l_q     <= 16'd1;
      wr_x_q       <= 16'd0;
      wr_y_q       <= 16'd0;
      frame_done_q <= 1'b0;
    end else begin
      xres_l_q     <= xres_l_d;
      yres_l_q     <= yres_l_d;
      wr_x_q       <= wr_x_d;
      wr_y_q       <= wr_y_d;
      frame_done_q <= frame_done_d;
    end
  end

  video_sync_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (vin_clk),
    .srst    (rst),
    .flush   (~frame_sync_n),
    .wr_en   (wr_fire),
    .wr_data (wr_entry),
    .rd_en   (vout_ready),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign vout_valid = ~fifo_empty;
  assign vout_dat   = rd_entry[ENTRY_W-1:ENTRY_FLAG_W];
  assign vout_sof   = rd_entry[ENTRY_SOF_BIT];
  assign vout_eol   = rd_entry[ENTRY_EOL_BIT];
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_video_scale_stream_packer.sv
// Bench for video_scale_stream_packer: directed table, corner-case sequences
// and a randomized run against a frame-position reference model.
module tb_video_scale_stream_packer;

  localparam int DEPTH = 16;

  logic        vin_clk = 1'b0;
  logic        rst;
  logic        frame_sync_n;
  logic [23:0] vin_dat;
  logic        vin_valid;
  logic        vin_ready;
  logic [23:0] vout_dat;
  logic        vout_valid;
  logic        vout_ready;
  logic        vout_sof;
  logic        vout_eol;
  logic [15:0] vout_xres;
  logic [15:0] vout_yres;
  logic        frame_done;
  logic [4:0]  fifo_level;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue of {pixel, sof, eol} plus position within frame.
  logic [25:0] mq[$];
  int          m_pos;
  int          m_xres;
  int          m_yres;
  logic        m_fd;
  logic        dut_rdy_s;

  typedef struct {
    logic        vld;
    logic [23:0] dat;
    logic        e_valid;
    logic [23:0] e_dat;
    logic        e_sof;
    logic        e_eol;
    logic        e_fd;
    logic [4:0]  e_lvl;
  } vec_t;

  vec_t tbl [9];

  always #5 vin_clk = ~vin_clk;

  video_scale_stream_packer dut (
    .vin_clk      (vin_clk),
    .rst          (rst),
    .frame_sync_n (frame_sync_n),
    .vin_dat      (vin_dat),
    .vin_valid    (vin_valid),
    .vin_ready    (vin_ready),
    .vout_dat     (vout_dat),
    .vout_valid   (vout_valid),
    .vout_ready   (vout_ready),
    .vout_sof     (vout_sof),
    .vout_eol     (vout_eol),
    .vout_xres    (vout_xres),
    .vout_yres    (vout_yres),
    .frame_done   (frame_done),
    .fifo_level   (fifo_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge vin_clk);
    #1;
  endtask

  // One model-checked cycle: drive, compare against model, clock, update model.
  task automatic cyc(input logic vld, input logic [23:0] dat, input logic rdy,
                     input logic sn, input logic r);
    logic exp_rdy;
    logic in_f;
    logic out_f;
    int   fsz;
    vin_valid    = vld;
    vin_dat      = dat;
    vout_ready   = rdy;
    frame_sync_n = sn;
    rst          = r;
    #1;
    exp_rdy   = !r && sn && (mq.size() < DEPTH);
    dut_rdy_s = vin_ready;
    chk("vin_ready",  32'(vin_ready),  32'(exp_rdy));
    chk("vout_valid", 32'(vout_valid), 32'(mq.size() > 0));
    chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    if (mq.size() > 0) begin
      chk("vout_dat", 32'(vout_dat), 32'(mq[0][25:2]));
      chk("vout_sof", 32'(vout_sof), 32'(mq[0][1]));
      chk("vout_eol", 32'(vout_eol), 32'(mq[0][0]));
    end
    in_f  = vld && exp_rdy;
    out_f = rdy && (mq.size() > 0);
    step();
    if (r) begin
      mq.delete();
      m_pos = 0; m_xres = 1; m_yres = 1; m_fd = 1'b0;
    end else if (!sn) begin
      mq.delete();
      m_pos  = 0;
      m_xres = (vout_xres == 16'd0) ? 1 : int'(vout_xres);
      m_yres = (vout_yres == 16'd0) ? 1 : int'(vout_yres);
      m_fd   = 1'b0;
    end else begin
      if (out_f) void'(mq.pop_front());
      m_fd = 1'b0;
      if (in_f) begin
        fsz = m_xres * m_yres;
        mq.push_back({dat, 1'(m_pos == 0), 1'((m_pos % m_xres) == m_xres - 1)});
        m_fd  = 1'(m_pos == fsz - 1);
        m_pos = (m_pos + 1) % fsz;
      end
    end
  endtask

  initial begin
    int acc;
    // xres=4, yres=2, pixels 1..8 with vout_ready=1, then one idle cycle.
    tbl[0] = '{1'b1, 24'd1, 1'b1, 24'd1, 1'b1, 1'b0, 1'b0, 5'd1};
    tbl[1] = '{1'b1, 24'd2, 1'b1, 24'd2, 1'b0, 1'b0, 1'b0, 5'd1};
    tbl[2] = '{1'b1, 24'd3, 1'b1, 24'd3, 1'b0, 1'b0, 1'b0, 5'd1};
    tbl[3] = '{1'b1, 24'd4, 1'b1, 24'd4, 1'b0, 1'b1, 1'b0, 5'd1};
    tbl[4] = '{1'b1, 24'd5, 1'b1, 24'd5, 1'b0, 1'b0, 1'b0, 5'd1};
    tbl[5] = '{1'b1, 24'd6, 1'b1, 24'd6, 1'b0, 1'b0, 1'b0, 5'd1};
    tbl[6] = '{1'b1, 24'd7, 1'b1, 24'd7, 1'b0, 1'b0, 1'b0, 5'd1};
    tbl[7] = '{1'b1, 24'd8, 1'b1, 24'd8, 1'b0, 1'b1, 1'b1, 5'd1};
    tbl[8] = '{1'b0, 24'd0, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 5'd0};

    rst = 1'b1; frame_sync_n = 1'b1; vin_valid = 1'b0; vin_dat = '0;
    vout_ready = 1'b0; vout_xres = 16'd4; vout_yres = 16'd2;
    step(); step();
    chk("rst_vout_valid", 32'(vout_valid), 32'd0);
    chk("rst_vout_sof",   32'(vout_sof),   32'd0);
    chk("rst_vout_eol",   32'(vout_eol),   32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst_vin_ready",  32'(vin_ready),  32'd0);
    chk("rst_vout_dat",   32'(vout_dat),   32'd0);

    rst = 1'b0; frame_sync_n = 1'b0;
    #1;
    chk("sync_vin_ready", 32'(vin_ready), 32'd0);
    step();
    frame_sync_n = 1'b1;
    #1;
    chk("first_vin_ready", 32'(vin_ready), 32'd1);

    for (int i = 0; i < 9; i++) begin
      vin_valid = tbl[i].vld; vin_dat = tbl[i].dat; vout_ready = 1'b1;
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(vout_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'(tbl[i].e_lvl));
      chk($sformatf("tbl%0d_fd", i),    32'(frame_done), 32'(tbl[i].e_fd));
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_dat", i), 32'(vout_dat), 32'(tbl[i].e_dat));
        chk($sformatf("tbl%0d_sof", i), 32'(vout_sof), 32'(tbl[i].e_sof));
        chk($sformatf("tbl%0d_eol", i), 32'(vout_eol), 32'(tbl[i].e_eol));
      end
    end

    // Model picks up here: 4x2 frame, counters back at origin, FIFO empty.
    m_pos = 0; m_xres = 4; m_yres = 2; m_fd = 1'b0; mq.delete();

    // Fill with 20 offers while stalled, then drain in order.
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 24'(100 + i), 1'b0, 1'b1, 1'b0);
      if (dut_rdy_s) acc++;
    end
    chk("fill_accepted", 32'(acc), 32'd16);
    chk("fill_vin_ready", 32'(vin_ready), 32'd0);
    chk("fill_level", 32'(fifo_level), 32'd16);
    for (int i = 0; i < 17; i++) cyc(1'b0, 24'd0, 1'b1, 1'b1, 1'b0);
    chk("drain_empty", 32'(vout_valid), 32'd0);

    // Full FIFO with write and read requested together.
    for (int i = 0; i < 16; i++) cyc(1'b1, 24'(200 + i), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 24'(300 + i), 1'b1, 1'b1, 1'b0);
      chk("full_rw_level", 32'(fifo_level >= 5'd15), 32'd1);
    end
    for (int i = 0; i < 17; i++) cyc(1'b0, 24'd0, 1'b1, 1'b1, 1'b0);

    // Mid-frame resync discards buffered pixels.
    for (int i = 0; i < 5; i++) cyc(1'b1, 24'(400 + i), 1'b0, 1'b1, 1'b0);
    chk("pre_sync_level", 32'(fifo_level), 32'd5);
    cyc(1'b0, 24'd0, 1'b0, 1'b0, 1'b0);
    chk("post_sync_level", 32'(fifo_level), 32'd0);
    cyc(1'b1, 24'd77, 1'b1, 1'b1, 1'b0);
    chk("post_sync_sof", 32'(vout_sof), 32'd1);
    chk("post_sync_dat", 32'(vout_dat), 32'd77);
    cyc(1'b0, 24'd0, 1'b1, 1'b1, 1'b0);

    // Zero resolution behaves as 1x1.
    vout_xres = 16'd0; vout_yres = 16'd0;
    cyc(1'b0, 24'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 24'(500 + i), 1'b1, 1'b1, 1'b0);
      chk("zero_res_sof", 32'(vout_sof), 32'd1);
      chk("zero_res_eol", 32'(vout_eol), 32'd1);
      chk("zero_res_fd",  32'(frame_done), 32'd1);
    end

    // Reset together with frame sync, mid-stream.
    vout_xres = 16'd3; vout_yres = 16'd3;
    cyc(1'b0, 24'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 24'(600 + i), 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 24'd700, 1'b1, 1'b0, 1'b1);
    chk("rst2_vout_valid", 32'(vout_valid), 32'd0);
    chk("rst2_vout_sof",   32'(vout_sof),   32'd0);
    chk("rst2_vout_eol",   32'(vout_eol),   32'd0);
    chk("rst2_frame_done", 32'(frame_done), 32'd0);
    chk("rst2_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst2_vin_ready",  32'(vin_ready),  32'd0);
    chk("rst2_vout_dat",   32'(vout_dat),   32'd0);
    vout_xres = 16'd4; vout_yres = 16'd2;
    cyc(1'b1, 24'd701, 1'b1, 1'b1, 1'b0);
    chk("rst2_res1_sof", 32'(vout_sof), 32'd1);
    chk("rst2_res1_eol", 32'(vout_eol), 32'd1);
    chk("rst2_res1_fd",  32'(frame_done), 32'd1);

    // Randomized traffic, resyncs, resolution changes and occasional reset.
    vout_xres = 16'd3; vout_yres = 16'd2;
    cyc(1'b0, 24'd0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 900; c++) begin
      logic sn;
      logic r;
      logic v;
      logic rd;
      sn = 1'b1;
      r  = 1'b0;
      if ($urandom_range(0, 19) == 0) vout_xres = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 19) == 0) vout_yres = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 69) == 0) sn = 1'b0;
      if ($urandom_range(0, 299) == 0) r = 1'b1;
      v  = ($urandom_range(0, 3) != 0);
      rd = ((c % 100) < 50) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) != 0);
      cyc(v, 24'($urandom), rd, sn, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
